// File: rtl/uart_tx_if.sv
// uart_tx request interface
// byte request, busy and end-of-frame between loop stage and transmitter
interface uart_tx_if;
  logic       send_en;
  logic [7:0] send_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output send_en,
    output send_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  send_en,
    input  send_data,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, LSB first
// optional odd/even parity, 1 or 2 stop bits
module uart_tx #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115200,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int DATA_LATCH_DLY = 1
) (
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  uart_tx_if.slave u_if,
  output logic     uart_txd
);

  localparam int BPS_CNT = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(BPS_CNT);

  localparam logic [CW-1:0] C_LAST = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] C_END  = CW'(BPS_CNT - 2);
  localparam logic          C_SLST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic            r_stop;
  logic [7:0]      r_shift;
  logic            r_load;
  logic            r_busy;
  logic            r_done;
  logic            r_txd;

  logic            w_idle;
  logic            w_wrap;
  logic            w_end;
  logic [2:0]      w_nidx;
  logic            w_par;

  assign w_idle = (r_state == S_IDLE);
  assign w_wrap = (r_cnt == C_LAST);
  assign w_nidx = r_idx + 3'd1;
  assign w_par  = (PARITY == 1) ? ~^r_shift : ^r_shift;

  // Frame ends one cycle before the last stop bit expires, so the
  // IDLE/tx_done cycle is that final stop cycle and a request seen
  // there starts the next frame with no idle gap on the line.
  assign w_end  = (r_cnt == C_END) && (r_stop == C_SLST);

  // Frame sequencer: bit timer, bit counters, data capture, line driver
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_stop  <= 1'b0;
      r_shift <= 8'd0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      r_load <= 1'b0;
      if (r_load) r_shift <= u_if.send_data;
      if (!w_idle) r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      unique case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (u_if.send_en) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
            r_txd   <= 1'b0;
            r_cnt   <= '0;
            if (DATA_LATCH_DLY == 0) r_shift <= u_if.send_data;
            else                     r_load  <= 1'b1;
          end
        end
        S_START: begin
          if (w_wrap) begin
            r_state <= S_DATA;
            r_idx   <= 3'd0;
            r_txd   <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_wrap) begin
            if (r_idx == 3'd7) begin
              if (PARITY != 0) begin
                r_state <= S_PAR;
                r_txd   <= w_par;
              end else begin
                r_state <= S_STOP;
                r_stop  <= 1'b0;
                r_txd   <= 1'b1;
              end
            end else begin
              r_idx <= w_nidx;
              r_txd <= r_shift[w_nidx];
            end
          end
        end
        S_PAR: begin
          if (w_wrap) begin
            r_state <= S_STOP;
            r_stop  <= 1'b0;
            r_txd   <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_end) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_wrap) begin
            r_stop <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_txd     = r_txd;
  assign u_if.tx_done = r_done;
  assign u_if.tx_busy = r_busy | (u_if.send_en & w_idle);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized frames on four uart_tx configurations
// line, busy and done compared cycle by cycle with a frame model
module tb_uart_tx;

  localparam int BPS = 10;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       en   [4];
  logic [7:0] dat  [4];
  logic       busy [4];
  logic       done [4];
  logic       txd  [4];

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_bits [12];

  always #5 sys_clk = ~sys_clk;

  function automatic int par_of(input int u);
    case (u)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_of(input int u);
    return (u == 3) ? 2 : 1;
  endfunction

  function automatic int lat_of(input int u);
    return (u == 2) ? 0 : 1;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gu
    uart_tx_if u_if ();
    assign u_if.send_en   = en[g];
    assign u_if.send_data = dat[g];
    assign busy[g]        = u_if.tx_busy;
    assign done[g]        = u_if.tx_done;
    uart_tx #(
      .CLK_FREQ       (1_000_000),
      .BAUD           (100_000),
      .PARITY         (par_of(g)),
      .STOP_BITS      (stop_of(g)),
      .DATA_LATCH_DLY (lat_of(g))
    ) u_dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .u_if      (u_if),
      .uart_txd  (txd[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // expected line levels of one frame, one entry per bit
  function automatic int build(input int u, input logic [7:0] d);
    int n;
    int ones;
    ones = $countones(d);
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
    n = 9;
    if (par_of(u) == 2) begin
      exp_bits[n] = (ones % 2) == 1;
      n++;
    end else if (par_of(u) == 1) begin
      exp_bits[n] = (ones % 2) == 0;
      n++;
    end
    for (int s = 0; s < stop_of(u); s++) begin
      exp_bits[n] = 1'b1;
      n++;
    end
    return n;
  endfunction

  // cycle 0 raises send_en; cycle j>0 carries bit (j-1)/BPS of the frame
  task automatic run(input int u, input logic [7:0] d, input int nfr,
                     input bit noise, input bit scripted);
    int   len;
    int   tot;
    logic ex_t;
    logic ex_d;
    logic ex_b;
    len = build(u, d) * BPS;
    tot = nfr * len;
    for (int j = 0; j <= tot + 1; j++) begin
      if (j == 0 || (nfr > 1 && j < tot)) en[u] = 1'b1;
      else if (noise && j < len) en[u] = 1'($urandom_range(0, 1));
      else en[u] = 1'b0;
      if (nfr > 1) dat[u] = d;
      else if (scripted) dat[u] = (j == 0) ? 8'h00 : (j == 1) ? d : 8'hFF;
      else if (j == lat_of(u)) dat[u] = d;
      else dat[u] = 8'($urandom);
      @(negedge sys_clk);
      ex_t = (j == 0 || j > tot) ? 1'b1 : exp_bits[((j - 1) % len) / BPS];
      ex_d = (j > 0) && (j <= tot) && (j % len == 0);
      ex_b = (j < tot);
      chk($sformatf("u%0d_txd_c%0d", u, j), 32'(txd[u]), 32'(ex_t));
      chk($sformatf("u%0d_done_c%0d", u, j), 32'(done[u]), 32'(ex_d));
      chk($sformatf("u%0d_busy_c%0d", u, j), 32'(busy[u]), 32'(ex_b));
      @(posedge sys_clk);
      #1;
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en[i]  = 1'b0;
      dat[i] = 8'h00;
    end
    repeat (2) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_txd%0d", i), 32'(txd[i]), 32'd1);
      chk($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
    end
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    run(0, 8'h55, 1, 0, 0);
    run(0, 8'($urandom), 1, 1, 0);
    run(0, 8'($urandom), 1, 1, 0);
    run(1, 8'h07, 1, 0, 0);
    run(1, 8'($urandom), 1, 1, 0);
    run(2, 8'h07, 1, 0, 0);
    run(2, 8'($urandom), 1, 1, 0);
    run(0, 8'hA3, 3, 0, 0);
    run(3, 8'hFF, 1, 0, 0);
    run(3, 8'($urandom), 1, 1, 0);

    en[0]  = 1'b1;
    dat[0] = 8'h96;
    @(posedge sys_clk);
    #1;
    en[0]  = 1'b0;
    dat[0] = 8'($urandom);
    repeat (44) begin
      @(posedge sys_clk);
      #1;
    end
    #2;
    chk("pre_rst_txd", 32'(txd[0]), 32'd0);
    chk("pre_rst_busy", 32'(busy[0]), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", 32'(txd[0]), 32'd1);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    chk("mid_rst_done", 32'(done[0]), 32'd0);
    repeat (3) @(negedge sys_clk);
    chk("hold_rst_txd", 32'(txd[0]), 32'd1);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    run(0, 8'($urandom), 1, 0, 0);

    run(0, 8'h3C, 1, 0, 1);

    for (int k = 0; k < 8; k++) begin
      run(int'($urandom_range(0, 3)), 8'($urandom), 1, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
